core_decode: RTL and testbench

//  RV32I decode stage; the producer side of core_alu's decoded-operation interface.

---
 rtl/core_decode.sv | 214 +++++++++++++++++++++
 tb/tb_core_decode.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_decode.sv
// RV32I decode stage: registered decode record behind a valid/ready handshake,
// with an optional one-entry skid buffer so inst_ready comes straight from a flop.
//
// state    | meaning
// ST_EMPTY | no record held, output invalid
// ST_OUT   | output register holds the oldest record
// ST_FULL  | output register plus skid both hold records, inst_ready low
module core_decode #(
    parameter bit SKID_EN    = 1'b1,
    parameter bit ZERO_X0_WE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [32:0] op,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic [31:0] imm,
    output logic        illegal
);

    typedef enum logic [1:0] {ST_EMPTY, ST_OUT, ST_FULL} state_t;

    typedef struct packed {
        logic [32:0] op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] imm;
        logic        illegal;
    } rec_t;

    state_t state_q, state_d;
    rec_t   out_q, out_d;
    rec_t   skid_q, skid_d;
    rec_t   dec;
    logic   inst_ready_q, inst_ready_d;
    logic   accept;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] op_idx;
    logic       hit, is_i, is_sh, is_r, is_b, is_ld, is_st;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    always_comb begin
        op_idx = '0;
        hit    = 1'b0;
        is_i   = 1'b0;
        is_sh  = 1'b0;
        is_r   = 1'b0;
        is_b   = 1'b0;
        is_ld  = 1'b0;
        is_st  = 1'b0;
        case (opc)
            7'b0010011: begin
                case (f3)
                    3'b000: begin op_idx = 6'd0; hit = 1'b1; is_i = 1'b1; end
                    3'b010: begin op_idx = 6'd1; hit = 1'b1; is_i = 1'b1; end
                    3'b011: begin op_idx = 6'd2; hit = 1'b1; is_i = 1'b1; end
                    3'b100: begin op_idx = 6'd3; hit = 1'b1; is_i = 1'b1; end
                    3'b110: begin op_idx = 6'd4; hit = 1'b1; is_i = 1'b1; end
                    3'b111: begin op_idx = 6'd5; hit = 1'b1; is_i = 1'b1; end
                    3'b001: if (f7 == 7'b0000000) begin op_idx = 6'd6; hit = 1'b1; is_sh = 1'b1; end
                    default: begin
                        if (f7 == 7'b0000000) begin op_idx = 6'd7; hit = 1'b1; is_sh = 1'b1; end
                        else if (f7 == 7'b0100000) begin op_idx = 6'd8; hit = 1'b1; is_sh = 1'b1; end
                    end
                endcase
            end
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    hit  = 1'b1;
                    is_r = 1'b1;
                    case (f3)
                        3'b000:  op_idx = 6'd9;
                        3'b001:  op_idx = 6'd11;
                        3'b010:  op_idx = 6'd12;
                        3'b011:  op_idx = 6'd13;
                        3'b100:  op_idx = 6'd14;
                        3'b101:  op_idx = 6'd15;
                        3'b110:  op_idx = 6'd17;
                        default: op_idx = 6'd18;
                    endcase
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    hit    = 1'b1;
                    is_r   = 1'b1;
                    op_idx = (f3 == 3'b000) ? 6'd10 : 6'd16;
                end
            end
            7'b1100011: begin
                if (f3[2:1] != 2'b01) begin
                    hit    = 1'b1;
                    is_b   = 1'b1;
                    op_idx = f3[2] ? (6'd19 + {4'd0, f3[1:0]}) : (6'd19 + {5'd0, f3[0]});
                end
            end
            7'b0000011: begin
                if (f3 != 3'b011 && f3[2:1] != 2'b11) begin
                    hit    = 1'b1;
                    is_ld  = 1'b1;
                    op_idx = f3[2] ? (6'd28 + {5'd0, f3[0]}) : (6'd25 + {4'd0, f3[1:0]});
                end
            end
            7'b0100011: begin
                if (f3[2] == 1'b0 && f3[1:0] != 2'b11) begin
                    hit    = 1'b1;
                    is_st  = 1'b1;
                    op_idx = 6'd30 + {4'd0, f3[1:0]};
                end
            end
            default: ;
        endcase
    end

    // Branch ops 21..24 sit after BEQ/BNE, so f3[1:0]+2 lands on BLT..BGEU.
    always_comb begin
        dec     = '0;
        dec.rs1 = inst[19:15];
        if (!hit) begin
            dec.illegal = 1'b1;
        end else begin
            dec.op = 33'd1 << op_idx;
            if (is_b && f3[2])
                dec.op = 33'd1 << (op_idx + 6'd2);
            if (is_r || is_b || is_st)
                dec.rs2 = inst[24:20];
            if (is_r || is_i || is_sh || is_ld)
                dec.rd = inst[11:7];
            dec.rd_we = (is_r || is_i || is_sh || is_ld) &&
                        !(ZERO_X0_WE && inst[11:7] == 5'd0);
            if (is_i || is_ld)
                dec.imm = {{20{inst[31]}}, inst[31:20]};
            else if (is_sh)
                dec.imm = {27'd0, inst[24:20]};
            else if (is_st)
                dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            else if (is_b)
                dec.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end
    end

    assign dec_valid  = (state_q != ST_EMPTY);
    assign inst_ready = SKID_EN ? inst_ready_q : (!dec_valid || dec_ready);
    assign accept     = inst_valid && inst_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: if (accept) begin
                out_d   = dec;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (accept && dec_ready) begin
                    out_d = dec;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = ST_FULL;
                end else if (dec_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: if (dec_ready) begin
                out_d   = skid_q;
                state_d = ST_OUT;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            out_d   = out_q;
            skid_d  = skid_q;
        end
        inst_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            out_q        <= '0;
            skid_q       <= '0;
            inst_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
            inst_ready_q <= inst_ready_d;
        end
    end

    assign op       = out_q.op;
    assign rs1_addr = out_q.rs1;
    assign rs2_addr = out_q.rs2;
    assign rd_addr  = out_q.rd;
    assign rd_we    = out_q.rd_we;
    assign imm      = out_q.imm;
    assign illegal  = out_q.illegal;

endmodule

// File: tb/tb_core_decode.sv
// Self-checking bench for core_decode: mask/match instruction table model plus
// an in-flight record queue that mirrors the handshake.
module tb_core_decode;

    logic        clk, rst_n, flush, inst_valid, inst_ready, dec_valid, dec_ready;
    logic [31:0] inst, imm;
    logic [32:0] op;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_we, illegal;

    core_decode dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .op(op), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rd_we(rd_we), .imm(imm), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] op;
        logic [4:0]  rs1, rs2, rd;
        logic        rd_we;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] match_t [33];
    logic [31:0] mask_t  [33];
    exp_t q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add_ent(input int k, input int opc, input int f3, input int f7);
        match_t[k] = 32'(opc) | (32'(f3) << 12) | ((f7 < 0) ? 32'd0 : (32'(f7) << 25));
        mask_t[k]  = (f7 < 0) ? 32'h0000707f : 32'hfe00707f;
    endtask

    task automatic build_table();
        int ii[6] = '{0, 2, 3, 4, 6, 7};
        int rf3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        int rf7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
        int bf3[6] = '{0, 1, 4, 5, 6, 7};
        int lf3[5] = '{0, 1, 2, 4, 5};
        for (int n = 0; n < 6; n++) add_ent(n, 'h13, ii[n], -1);
        add_ent(6, 'h13, 1, 0);
        add_ent(7, 'h13, 5, 0);
        add_ent(8, 'h13, 5, 32);
        for (int n = 0; n < 10; n++) add_ent(9 + n, 'h33, rf3[n], rf7[n]);
        for (int n = 0; n < 6; n++) add_ent(19 + n, 'h63, bf3[n], -1);
        for (int n = 0; n < 5; n++) add_ent(25 + n, 'h03, lf3[n], -1);
        for (int n = 0; n < 3; n++) add_ent(30 + n, 'h23, n, -1);
    endtask

    function automatic exp_t ref_decode(input logic [31:0] i);
        exp_t e;
        int k = -1;
        logic [31:0] sx;
        for (int n = 0; n < 33; n++) if ((i & mask_t[n]) == match_t[n]) k = n;
        e.rs1 = 5'((i >> 15) & 32'h1f);
        e.op = '0; e.rs2 = '0; e.rd = '0; e.rd_we = 1'b0; e.imm = '0; e.ill = 1'b1;
        if (k >= 0) begin
            e.ill = 1'b0;
            e.op  = 33'd1 << k;
            if ((k >= 9 && k <= 24) || k >= 30) e.rs2 = 5'((i >> 20) & 32'h1f);
            if (k <= 18 || (k >= 25 && k <= 29)) begin
                e.rd    = 5'((i >> 7) & 32'h1f);
                e.rd_we = (e.rd != 0);
            end
            sx = i[31] ? 32'hffffffff : 32'h0;
            if (k <= 5 || (k >= 25 && k <= 29))
                e.imm = 32'($signed(i) >>> 20);
            else if (k <= 8)
                e.imm = (i >> 20) & 32'h1f;
            else if (k >= 30)
                e.imm = ((sx << 11)) | (((i >> 25) & 32'h7f) << 5) | ((i >> 7) & 32'h1f);
            else if (k >= 19)
                e.imm = (sx << 12) | (((i >> 7) & 1) << 11) | (((i >> 25) & 32'h3f) << 5) | (((i >> 8) & 32'hf) << 1);
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r = $urandom;
        int kind = $urandom_range(0, 3);
        int k = $urandom_range(0, 32);
        if (kind == 0) return r;
        r = (r & ~mask_t[k]) | match_t[k];
        if (kind == 3) r = r ^ (32'h1 << $urandom_range(25, 31));
        if ($urandom_range(0, 7) == 0) r = r & ~32'h00000f80;
        return r;
    endfunction

    task automatic verify();
        check_eq("dec_valid", dec_valid, q.size() != 0);
        check_eq("inst_ready", inst_ready, q.size() < 2);
        if (q.size() != 0) begin
            check_eq("op", op, q[0].op);
            check_eq("illegal", illegal, q[0].ill);
            check_eq("rd_we", rd_we, q[0].rd_we);
            check_eq("imm", imm, q[0].imm);
            if (!q[0].ill) begin
                check_eq("rs1", rs1_addr, q[0].rs1);
                check_eq("rs2", rs2_addr, q[0].rs2);
                check_eq("rd", rd_addr, q[0].rd);
            end
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] ins, input logic dr, input logic fl);
        inst_valid = iv; inst = ins; dec_ready = dr; flush = fl;
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && dr) void'(q.pop_front());
            if (iv && inst_ready) q.push_back(ref_decode(ins));
        end
        @(posedge clk); #1;
        verify();
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_valid"}, dec_valid, 0);
        check_eq({tag, "_op"}, op, 0);
        check_eq({tag, "_imm"}, imm, 0);
        check_eq({tag, "_addrs"}, {rs1_addr, rs2_addr, rd_addr}, 0);
        check_eq({tag, "_we_ill"}, {rd_we, illegal}, 0);
        check_eq({tag, "_ready"}, inst_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        build_table();
        rst_n = 1'b0; flush = 1'b0; inst_valid = 1'b0; dec_ready = 1'b0; inst = '0;
        #2;
        check_cleared("reset");
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        verify();

        step(1, 32'h00F08293, 1, 0);
        check_eq("addi_op", op, 33'd1);
        check_eq("addi_regs", {rs1_addr, rd_addr, rd_we}, {5'd1, 5'd5, 1'b1});
        check_eq("addi_imm", imm, 32'h0000000F);

        step(1, 32'h40415193, 1, 0);
        check_eq("srai_op", op, 33'd1 << 8);
        check_eq("srai_imm", imm, 32'h4);
        check_eq("srai_rs2", rs2_addr, 0);

        step(1, 32'h42415193, 1, 0);
        check_eq("srai_bad", {illegal, op}, {1'b1, 33'd0});

        step(1, 32'hFE208EE3, 1, 0);
        check_eq("beq_op", op, 33'd1 << 19);
        check_eq("beq_regs", {rs1_addr, rs2_addr, rd_we}, {5'd1, 5'd2, 1'b0});
        check_eq("beq_imm", imm, 32'hFFFFFFFC);

        step(1, 32'h00100013, 1, 0);
        check_eq("x0_we", rd_we, 0);

        step(1, 32'hFFFFFFFF, 1, 0);
        check_eq("ones", {dec_valid, illegal, rd_we, op}, {1'b1, 1'b1, 1'b0, 33'd0});

        step(0, 32'h0, 1, 0);
        step(1, 32'h002081B3, 0, 0);
        step(1, 32'h402081B3, 0, 0);
        check_eq("bp_hold_op", op, 33'd1 << 9);
        check_eq("bp_ready", inst_ready, 0);
        step(0, 32'h0, 1, 0);
        check_eq("bp_sub_op", op, 33'd1 << 10);
        step(0, 32'h0, 1, 0);
        check_eq("bp_drained", dec_valid, 0);

        step(1, 32'h002081B3, 0, 0);
        step(1, 32'h402081B3, 0, 0);
        step(1, 32'h00F08293, 1, 1);
        check_eq("flush_state", {dec_valid, inst_ready}, {1'b0, 1'b1});
        repeat (3) step(0, 32'h0, 1, 0);
        check_eq("flush_quiet", dec_valid, 0);

        step(1, 32'h002081B3, 0, 0);
        step(1, 32'h00F08293, 0, 1);
        check_eq("flush_accept", dec_valid, 0);
        step(0, 32'h0, 1, 0);

        step(1, 32'h002081B3, 0, 0);
        step(1, 32'h402081B3, 0, 0);
        #3 rst_n = 1'b0;
        #1 check_cleared("async_rst");
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        verify();

        repeat (3000)
            step($urandom_range(0, 9) < 7, gen_inst(), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 49) == 0);
        repeat (4) step(0, 32'h0, 1, 0);
        check_eq("final_empty", dec_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
